// File: rtl/freq_signal_gen_if.sv
// Control/status bundle for freq_signal_gen.
//   start, stop, freq_in        : requests from the controlling block (master)
//   busy, done_tick, error_tick : generator status (slave)
//   period_out                  : last computed period in clock cycles
//   signal_out                  : generated pulse train
interface freq_signal_gen_if #(
  parameter int unsigned FREQ_W = 14,
  parameter int unsigned CNT_W  = 27
);
  logic              start;
  logic              stop;
  logic [FREQ_W-1:0] freq_in;
  logic              busy;
  logic              done_tick;
  logic              error_tick;
  logic [CNT_W-1:0]  period_out;
  logic              signal_out;

  modport master (
    output start, stop, freq_in,
    input  busy, done_tick, error_tick, period_out, signal_out
  );

  modport slave (
    input  start, stop, freq_in,
    output busy, done_tick, error_tick, period_out, signal_out
  );
endinterface

// File: rtl/freq_signal_gen.sv
// Programmable test-signal source. A requested frequency in Hz is turned into a
// period of CLK_FREQ/freq clock cycles by a restoring divider (one quotient bit
// per cycle), after which a continuous pulse train is emitted: PULSE_CYCLES high,
// the rest of each period low.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : freq_signal_gen_if.slave (start/stop/freq_in in; busy, done_tick,
//           error_tick, period_out, signal_out out, all registered)
module freq_signal_gen #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned FREQ_W       = 14,
  parameter int unsigned CNT_W        = 27,
  parameter int unsigned PULSE_CYCLES = 20
) (
  input  logic            clk,
  input  logic            reset,
  freq_signal_gen_if.slave bus
);

  localparam int unsigned FREQ_MAX = 9999;
  localparam int unsigned REM_W    = FREQ_W + 1;
  localparam int unsigned BIT_W    = $clog2(CNT_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CNT_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_RUN} state_t;

  state_t            state;
  logic [FREQ_W-1:0] freq_q;
  logic [REM_W-1:0]  rem_q;
  logic [CNT_W-1:0]  quo_q;
  logic [BIT_W-1:0]  bit_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              freq_ok_c;
  logic [REM_W-1:0]  rem_sh_c;
  logic              rem_ge_c;
  logic [REM_W-1:0]  rem_nx_c;
  logic [CNT_W-1:0]  quo_nx_c;
  logic [CNT_W-1:0]  cnt_nx_c;

  // Accept only 1..FREQ_MAX Hz; anything else is rejected with error_tick.
  assign freq_ok_c = (bus.freq_in != '0) && (32'(bus.freq_in) <= FREQ_MAX);

  // One restoring-division step: shift the dividend MSB into the remainder and
  // subtract the divisor when it fits. Remainder stays < freq, so FREQ_W bits
  // of it plus the incoming bit always fit in REM_W.
  assign rem_sh_c = {rem_q[FREQ_W-1:0], quo_q[CNT_W-1]};
  assign rem_ge_c = (rem_sh_c >= {1'b0, freq_q});
  assign rem_nx_c = rem_ge_c ? (rem_sh_c - {1'b0, freq_q}) : rem_sh_c;
  assign quo_nx_c = {quo_q[CNT_W-2:0], rem_ge_c};

  // Free-running period counter, wraps at period_out-1.
  assign cnt_nx_c = (cnt_q == bus.period_out - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);

  // Control FSM, divider datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      freq_q         <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      bit_q          <= '0;
      cnt_q          <= '0;
      bus.busy       <= 1'b0;
      bus.done_tick  <= 1'b0;
      bus.error_tick <= 1'b0;
      bus.period_out <= '0;
      bus.signal_out <= 1'b0;
    end else begin
      bus.done_tick  <= 1'b0;
      bus.error_tick <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (freq_ok_c) begin
              freq_q   <= bus.freq_in;
              rem_q    <= '0;
              quo_q    <= CNT_W'(CLK_FREQ);
              bit_q    <= '0;
              bus.busy <= 1'b1;
              state    <= S_DIV;
            end else begin
              bus.error_tick <= 1'b1;
            end
          end
        end
        S_DIV: begin
          if (bus.stop) begin
            state          <= S_IDLE;
            bus.busy       <= 1'b0;
            bus.signal_out <= 1'b0;
          end else begin
            rem_q <= rem_nx_c;
            quo_q <= quo_nx_c;
            bit_q <= bit_q + BIT_W'(1);
            // Last quotient bit: publish the period and start the train at once.
            if (bit_q == LAST_BIT) begin
              bus.period_out <= quo_nx_c;
              cnt_q          <= '0;
              bus.done_tick  <= 1'b1;
              bus.signal_out <= 1'b1;
              state          <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            state          <= S_IDLE;
            bus.busy       <= 1'b0;
            bus.signal_out <= 1'b0;
          end else if (bus.start && freq_ok_c) begin
            freq_q         <= bus.freq_in;
            rem_q          <= '0;
            quo_q          <= CNT_W'(CLK_FREQ);
            bit_q          <= '0;
            bus.signal_out <= 1'b0;
            state          <= S_DIV;
          end else begin
            // A rejected restart flags an error but leaves the old train running.
            if (bus.start) begin
              bus.error_tick <= 1'b1;
            end
            cnt_q          <= cnt_nx_c;
            bus.signal_out <= (cnt_nx_c < CNT_W'(PULSE_CYCLES));
          end
        end
        default: begin
          state          <= S_IDLE;
          bus.busy       <= 1'b0;
          bus.signal_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_signal_gen.sv
// Testbench for freq_signal_gen: stimulus pushes timed expectations into a
// queue; a monitor on the falling edge applies them and compares every cycle.
module tb_freq_signal_gen;

  localparam int CLK_FREQ = 100_000_000;
  localparam int FREQ_W   = 14;
  localparam int CNT_W    = 27;
  localparam int PULSE    = 20;
  localparam int LAT      = CNT_W;  // edges from the start-sampling edge to done_tick

  typedef enum int {EV_ERR, EV_DIV, EV_DONE, EV_HALT, EV_RST} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       due;
    int       period;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  bit   mon_en = 0;
  ev_t  evq[$];

  // Stimulus-side knowledge of what it has asked for.
  bit st_active = 0;
  int st_done_at = 0;

  // Monitor-side reference model.
  bit m_busy = 0;
  bit m_run = 0;
  int m_t0 = 0;
  int m_period = 1;
  int m_last = 0;

  freq_signal_gen_if #(.FREQ_W(FREQ_W), .CNT_W(CNT_W)) bus ();

  freq_signal_gen #(
    .CLK_FREQ(CLK_FREQ), .FREQ_W(FREQ_W), .CNT_W(CNT_W), .PULSE_CYCLES(PULSE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic cancel_from(input int k);
    while (evq.size() != 0 && evq[evq.size()-1].due >= k) void'(evq.pop_back());
  endtask

  // Drive one cycle of start/stop/freq_in and record what must follow.
  task automatic issue(input bit s, input bit p, input int f);
    int k;
    ev_t ev;
    k = cyc + 1;
    bus.start   = s;
    bus.stop    = p;
    bus.freq_in = FREQ_W'(f);
    if (p && st_active) begin
      cancel_from(k);
      ev = '{EV_HALT, k, 0};
      evq.push_back(ev);
      st_active = 0;
    end else if (s) begin
      if (f >= 1 && f <= 9999) begin
        ev = '{EV_DIV, k, 0};
        evq.push_back(ev);
        ev = '{EV_DONE, k + LAT, CLK_FREQ / f};
        evq.push_back(ev);
        st_active  = 1;
        st_done_at = k + LAT;
      end else begin
        ev = '{EV_ERR, k, 0};
        evq.push_back(ev);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic do_reset();
    int k;
    ev_t ev;
    k = cyc + 1;
    reset = 1'b1;
    cancel_from(k);
    ev = '{EV_RST, k, 0};
    evq.push_back(ev);
    st_active = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: apply due expectations, then compare all outputs.
  always @(negedge clk) begin
    bit exp_done;
    bit exp_err;
    bit exp_sig;
    ev_t ev;
    if (mon_en) begin
      exp_done = 0;
      exp_err  = 0;
      while (evq.size() != 0 && evq[0].due <= cyc) begin
        ev = evq.pop_front();
        case (ev.kind)
          EV_ERR: exp_err = 1;
          EV_DIV: begin
            m_busy = 1;
            m_run  = 0;
          end
          EV_DONE: begin
            exp_done = 1;
            m_run    = 1;
            m_t0     = cyc;
            m_period = ev.period;
            m_last   = ev.period;
            check("period_out", 64'(bus.period_out), 64'(ev.period));
          end
          EV_HALT: begin
            m_busy = 0;
            m_run  = 0;
            check("period_held", 64'(bus.period_out), 64'(m_last));
          end
          default: begin
            m_busy = 0;
            m_run  = 0;
            m_last = 0;
            check("period_reset", 64'(bus.period_out), 64'(0));
          end
        endcase
      end
      exp_sig = m_run && (((cyc - m_t0) % m_period) < PULSE);
      check("done_tick", 64'(bus.done_tick), 64'(exp_done));
      check("error_tick", 64'(bus.error_tick), 64'(exp_err));
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("signal_out", 64'(bus.signal_out), 64'(exp_sig));
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: cycle %0d reached, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.freq_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done_tick), 64'(0));
    check("rst_error", 64'(bus.error_tick), 64'(0));
    check("rst_period", 64'(bus.period_out), 64'(0));
    check("rst_signal", 64'(bus.signal_out), 64'(0));
    reset  = 1'b0;
    mon_en = 1;
    repeat (3) @(negedge clk);

    // 6342 Hz: three full periods of 20 high / 15747 low.
    issue(1, 0, 6342);
    wait_until(st_done_at + 3 * 15767 + 5);

    // Restart at 1685 Hz, rejected restart keeps the train, then the 9999 Hz boundary.
    issue(1, 0, 1685);
    wait_until(st_done_at + 200);
    issue(1, 0, 0);
    repeat (50) @(negedge clk);
    issue(1, 0, 9999);
    wait_until(st_done_at + 10001 + 30);
    issue(0, 1, 0);
    repeat (5) @(negedge clk);

    // Rejections from idle.
    issue(1, 0, 0);
    repeat (3) @(negedge clk);
    issue(1, 0, 10000);
    repeat (3) @(negedge clk);
    issue(1, 0, 16383);
    repeat (3) @(negedge clk);

    // Stop mid-division, stop mid-pulse, start+stop together while running.
    issue(1, 0, 4000);
    wait_until(cyc + 10);
    issue(0, 1, 0);
    repeat (5) @(negedge clk);
    issue(1, 0, 8000);
    wait_until(st_done_at + 5);
    issue(0, 1, 0);
    repeat (5) @(negedge clk);
    issue(1, 0, 7000);
    wait_until(st_done_at + 100);
    issue(1, 1, 5000);
    repeat (5) @(negedge clk);

    // Reset in the high phase, then a fresh start with identical timing.
    issue(1, 0, 6342);
    wait_until(st_done_at + 10);
    do_reset();
    repeat (3) @(negedge clk);
    issue(1, 0, 6342);
    wait_until(st_done_at + 100);

    // Random restarts, rejections and stops.
    for (int i = 0; i < 12; i++) begin
      int r;
      int f;
      r = int'($urandom_range(0, 3));
      if (r == 0) f = (i % 2 == 1) ? 0 : int'($urandom_range(10000, 16383));
      else        f = int'($urandom_range(1, 9999));
      if (st_active && r == 3 && (i % 2 == 1)) issue(0, 1, 0);
      else                                     issue(1, 0, f);
      repeat ($urandom_range(30, 400)) @(negedge clk);
    end

    if (st_active) issue(0, 1, 0);
    repeat (5) @(negedge clk);
    check("queue_drained", 64'(evq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
